// File: rtl/dwt_frame_buffer_pkg.sv
// Shared constants for the DWT ping-pong frame buffer: defaults, pair packing
// offsets and the read-side state encoding.
package dwt_frame_buffer_pkg;
  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_FRAME_LEN  = 32;

  // A pair is packed {d, a}; a sits at bit 0 and d starts one coefficient up.
  localparam int A_LSB = 0;
  localparam int D_LSB = DEF_DATA_WIDTH;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_e;
endpackage

// File: rtl/dwt_fb_bank.sv
// One frame bank: FRAME_LEN pair registers with a write port, a combinational
// read port and a full flag that the top sets on the last write and clears on drain.
module dwt_fb_bank
  import dwt_frame_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAME_LEN  = DEF_FRAME_LEN
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_wr_en,
  input  logic [$clog2(FRAME_LEN)-1:0]      i_wr_addr,
  input  logic [2*DATA_WIDTH-1:0]           i_wr_data,
  input  logic [$clog2(FRAME_LEN)-1:0]      i_rd_addr,
  output logic [2*DATA_WIDTH-1:0]           o_rd_data,
  input  logic                              i_set_full,
  input  logic                              i_clr_full,
  output logic                              o_full
);
  logic [FRAME_LEN-1:0][2*DATA_WIDTH-1:0] r_mem;
  logic                                   r_full;

  // Storage has no reset: contents are only read after being written.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_full <= 1'b0;
    else if (i_set_full) r_full <= 1'b1;
    else if (i_clr_full) r_full <= 1'b0;
  end

  assign o_rd_data = r_mem[i_rd_addr];
  assign o_full    = r_full;
endmodule

// File: rtl/dwt_frame_buffer.sv
// Ping-pong frame buffer between the DWT and the CNN input layer. Fills one bank
// while the other streams out over valid/ready; drops and flags pairs when both are full.
module dwt_frame_buffer
  import dwt_frame_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAME_LEN  = DEF_FRAME_LEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_enable,
  input  logic [DATA_WIDTH-1:0]   dwt_a_in,
  input  logic [DATA_WIDTH-1:0]   dwt_d_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    overflow,
  input  logic                    clr_overflow
);
  localparam int ADDR_WIDTH = $clog2(FRAME_LEN);
  localparam int PAIR_W     = 2 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

  logic                  r_wr_bank, r_rd_bank;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic                  r_overflow;
  rd_state_e             r_state, w_state_nxt;

  logic [1:0]             w_full;
  logic [1:0][PAIR_W-1:0] w_rd_data;
  logic [PAIR_W-1:0]      w_pair;
  logic                   w_wr_accept, w_wr_done, w_drop;
  logic                   w_rd_last, w_rd_fire, w_rd_done, w_stream;

  assign w_pair[A_LSB +: DATA_WIDTH]              = dwt_a_in;
  assign w_pair[A_LSB + DATA_WIDTH +: DATA_WIDTH] = dwt_d_in;

  assign w_wr_accept = in_enable && !w_full[r_wr_bank];
  assign w_drop      = in_enable &&  w_full[r_wr_bank];
  assign w_wr_done   = w_wr_accept && (r_wr_ptr == LAST_ADDR);

  assign w_stream  = (r_state == ST_STREAM);
  assign w_rd_last = (r_rd_ptr == LAST_ADDR);
  assign w_rd_fire = w_stream && out_ready;
  assign w_rd_done = w_rd_fire && w_rd_last;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dwt_fb_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAME_LEN  (FRAME_LEN)
    ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_en    (w_wr_accept && (r_wr_bank == 1'(b))),
      .i_wr_addr  (r_wr_ptr),
      .i_wr_data  (w_pair),
      .i_rd_addr  (r_rd_ptr),
      .o_rd_data  (w_rd_data[b]),
      .i_set_full (w_wr_done && (r_wr_bank == 1'(b))),
      .i_clr_full (w_rd_done && (r_rd_bank == 1'(b))),
      .o_full     (w_full[b])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_full[r_rd_bank]) w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_rd_done)         w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_bank  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_bank  <= 1'b0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_accept) begin
        r_wr_ptr <= w_wr_done ? '0 : r_wr_ptr + 1'b1;
        if (w_wr_done) r_wr_bank <= ~r_wr_bank;
      end
      if (w_rd_fire) begin
        r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + 1'b1;
        if (w_rd_last) r_rd_bank <= ~r_rd_bank;
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop)            r_overflow <= 1'b1;
      else if (clr_overflow) r_overflow <= 1'b0;
    end
  end

  assign out_valid = w_stream;
  assign out_data  = w_stream ? w_rd_data[r_rd_bank] : '0;
  assign out_last  = w_stream && w_rd_last;
  assign overflow  = r_overflow;
endmodule

// File: tb/tb_dwt_frame_buffer.sv
// Bench for dwt_frame_buffer at FRAME_LEN=4: directed cases from the test plan,
// then a randomized phase, all checked against a frame-level queue model.
module tb_dwt_frame_buffer;
  localparam int DW = 12;
  localparam int FL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_enable = 1'b0;
  logic [DW-1:0] dwt_a_in = '0, dwt_d_in = '0;
  logic          out_valid, out_last, overflow;
  logic          out_ready = 1'b1;
  logic          clr_overflow = 1'b0;
  logic [2*DW-1:0] out_data;

  dwt_frame_buffer #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .in_enable(in_enable), .dwt_a_in(dwt_a_in),
    .dwt_d_in(dwt_d_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: accepted pairs queue in order; a frame is pending once
  // FL pairs have been accepted and until its last beat transfers. A pair is
  // dropped exactly when two frames are pending.
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] obs_q[$];
  int   pending = 0, fill = 0, rbeat = 0;
  logic ov = 1'b0;
  logic stall_prev = 1'b0;
  logic [2*DW:0] prev_out = '0;

  always @(negedge clk) begin
    logic drop;
    if (!rst_n) begin
      exp_q.delete();
      pending = 0; fill = 0; rbeat = 0; ov = 1'b0; stall_prev = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_last",  out_last, 0);
      chk("rst_data",  out_data, 0);
      chk("rst_ovf",   overflow, 0);
    end else begin
      chk("overflow", overflow, ov);
      chk("valid_without_frame", out_valid && (pending == 0), 0);
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data_last", {out_last, out_data}, prev_out);
      end
      if (out_valid) chk("last_flag", out_last, rbeat == FL - 1);
      drop = in_enable && (pending == 2);
      if (out_valid && out_ready) begin
        obs_q.push_back(out_data);
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else chk("beat_data", out_data, exp_q.pop_front());
        rbeat++;
        if (rbeat == FL) begin rbeat = 0; pending--; end
      end
      if (in_enable && !drop) begin
        exp_q.push_back({dwt_d_in, dwt_a_in});
        fill++;
        if (fill == FL) begin fill = 0; pending++; end
      end
      ov = drop ? 1'b1 : (clr_overflow ? 1'b0 : ov);
      stall_prev = out_valid && !out_ready;
      prev_out = {out_last, out_data};
    end
  end

  task automatic put(input int a, input int d);
    in_enable = 1'b1; dwt_a_in = DW'(a); dwt_d_in = DW'(d);
    @(posedge clk); #1;
    in_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    @(negedge clk);
    while (!out_valid && k < 50) begin @(negedge clk); k++; end
    if (!out_valid) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    // Reset asserts asynchronously, mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ovf", overflow, 0);
    idle(2); rst_n = 1'b1; idle(2);

    // Single frame: last write in cycle k, first beat in cycle k+2.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) put(i, -i);
    @(negedge clk); chk("lat_k1_valid", out_valid, 0);
    @(negedge clk); chk("lat_k2_valid", out_valid, 1);
    chk("sf_beat1", {out_last, out_data}, 25'h0FFF001);
    @(negedge clk); chk("sf_beat2", {out_last, out_data}, 25'h0FFE002);
    @(negedge clk); chk("sf_beat3", {out_last, out_data}, 25'h0FFD003);
    @(negedge clk); chk("sf_beat4", {out_last, out_data}, 25'h1FFC004);
    @(negedge clk); chk("sf_after_valid", out_valid, 0);
    idle(4);

    // Backpressure on beat 2 for three cycles.
    for (int i = 1; i <= 4; i++) put(i, -i);
    wait_valid("bp");
    chk("bp_beat1", out_data, 24'hFFF001);
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall", {out_valid, out_last, out_data}, 26'h2FFE002);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); chk("bp_beat2", {out_last, out_data}, 25'h0FFE002);
    @(negedge clk); chk("bp_beat3", {out_last, out_data}, 25'h0FFD003);
    @(negedge clk); chk("bp_beat4", {out_last, out_data}, 25'h1FFC004);
    idle(4);

    // Overflow: nine pairs into two banks with the consumer stalled.
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) put(i, i);
    @(negedge clk); chk("ovf_set", overflow, 1);
    obs_q.delete();
    @(posedge clk); #1 out_ready = 1'b1;
    idle(20);
    chk("ovf_beats", obs_q.size(), 8);
    if (obs_q.size() == 8) begin
      chk("ovf_first", obs_q[0], 24'h001001);
      chk("ovf_f1_last", obs_q[3], 24'h004004);
      chk("ovf_f2_first", obs_q[4], 24'h005005);
      chk("ovf_f2_last", obs_q[7], 24'h008008);
    end
    chk("ovf_sticky", overflow, 1);
    clr_overflow = 1'b1; idle(1); clr_overflow = 1'b0;
    @(negedge clk); chk("ovf_cleared", overflow, 0);
    idle(2);

    // Continuous ping-pong, one pair every fourth cycle.
    obs_q.delete();
    for (int f = 0; f < 20 * FL; f++) begin
      put(f, 2000 - f);
      idle(3);
    end
    idle(10);
    chk("pp_beats", obs_q.size(), 20 * FL);
    if (obs_q.size() == 20 * FL) chk("pp_last_data", obs_q[20*FL-1], {12'(2000 - 79), 12'd79});
    chk("pp_no_ovf", overflow, 0);

    // Reset during beat 2, then a fresh frame.
    for (int i = 5; i <= 8; i++) put(i, -i);
    wait_valid("rs");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    obs_q.delete();
    for (int i = 0; i < 4; i++) put(32 + i, 48 + i);
    idle(10);
    chk("rs_beats", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      chk("rs_first", obs_q[0], 24'h030020);
      chk("rs_fourth", obs_q[3], 24'h033023);
    end

    // Randomized traffic, consumer stalls and overflow clears.
    for (int c = 0; c < 3000; c++) begin
      in_enable    = ($urandom % 3) == 0;
      dwt_a_in     = DW'($urandom);
      dwt_d_in     = DW'($urandom);
      out_ready    = ($urandom % 4) != 0;
      clr_overflow = ($urandom % 60) == 0;
      @(posedge clk); #1;
    end
    in_enable = 1'b0; clr_overflow = 1'b0; out_ready = 1'b1;
    idle(30);
    @(negedge clk); chk("rand_drained", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
